// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 32-bit CPU word port
// in front of a 256-bit line-wide physical memory port, one request in flight.
module l1_dcache #(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata
);
    localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
    localparam int N_SETS = 2 ** S_INDEX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [N_SETS-1:0]   valid_r, dirty_r;
    logic [S_TAG-1:0]    tag_r  [N_SETS];
    logic [255:0]        data_r [N_SETS];

    logic [31:2]         addr_r;
    logic [3:0]          be_r;
    logic [31:0]         wdata_r;
    logic                is_write_r;

    logic [S_TAG-1:0]    tag_s;
    logic [S_INDEX-1:0]  idx_s;
    logic [2:0]          word_s;
    logic                hit_s, hit_wr_s, wb_done_s, fill_done_s;
    logic                addr_lsb_unused_s;

    function automatic logic [31:0] line_word(input logic [255:0] line, input logic [2:0] w);
        return line[int'(w) * 32 +: 32];
    endfunction

    function automatic logic [255:0] merge_word(input logic [255:0] line, input logic [2:0] w,
                                                input logic [3:0] be, input logic [31:0] wdata);
        logic [255:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[int'(w) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
        end
        return res;
    endfunction

    assign addr_lsb_unused_s = ^mem_address[1:0];
    assign tag_s  = addr_r[31 -: S_TAG];
    assign idx_s  = addr_r[S_OFFSET +: S_INDEX];
    assign word_s = addr_r[4:2];
    assign hit_s  = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

    // Next-state logic and all port outputs; IDLE drives every output to zero.
    always_comb begin
        next_state_s = state_r;
        mem_resp     = 1'b0;
        mem_rdata    = 32'h0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0;
        pmem_wdata   = 256'h0;
        hit_wr_s     = 1'b0;
        wb_done_s    = 1'b0;
        fill_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_read || mem_write) next_state_s = CHECK;
                else                       next_state_s = IDLE;
            end
            CHECK: begin
                if (hit_s) begin
                    mem_resp     = 1'b1;
                    next_state_s = IDLE;
                    if (is_write_r) hit_wr_s  = 1'b1;
                    else            mem_rdata = line_word(data_r[idx_s], word_s);
                end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
                    next_state_s = WRITEBACK;
                end else begin
                    next_state_s = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_r[idx_s], idx_s, {S_OFFSET{1'b0}}};
                pmem_wdata   = data_r[idx_s];
                if (pmem_resp) begin
                    wb_done_s    = 1'b1;
                    next_state_s = FILL;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_s, idx_s, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    fill_done_s  = 1'b1;
                    next_state_s = CHECK;
                end else begin
                    next_state_s = FILL;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, latched request and per-set valid/dirty bits (async reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            addr_r     <= 30'h0;
            be_r       <= 4'h0;
            wdata_r    <= 32'h0;
            is_write_r <= 1'b0;
            valid_r    <= {N_SETS{1'b0}};
            dirty_r    <= {N_SETS{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == IDLE && (mem_read || mem_write)) begin
                addr_r     <= mem_address[31:2];
                be_r       <= mem_byte_enable;
                wdata_r    <= mem_wdata;
                is_write_r <= mem_write;
            end
            if (hit_wr_s)  dirty_r[idx_s] <= 1'b1;
            if (wb_done_s) dirty_r[idx_s] <= 1'b0;
            if (fill_done_s) begin
                valid_r[idx_s] <= 1'b1;
                dirty_r[idx_s] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked by valid_r.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            data_r[idx_s] <= pmem_rdata;
            tag_r[idx_s]  <= tag_s;
        end else if (hit_wr_s) begin
            data_r[idx_s] <= merge_word(data_r[idx_s], word_s, be_r, wdata_r);
        end
    end
endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios plus randomized traffic
// checked against a flat word memory and a set-residency model.
module tb_l1_dcache;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    int checks = 0;
    int failures = 0;
    int n_rd = 0, n_wr = 0, overlap_cnt = 0;
    logic [31:0]  last_rd_addr = 32'h0, last_wr_addr = 32'h0;
    logic [255:0] last_wr_data = 256'h0;
    bit pmem_hold = 1'b0;

    logic [255:0] bstore [int unsigned];
    logic [31:0]  flat   [int unsigned];
    bit           mdl_valid [16];
    bit           mdl_dirty [16];
    logic [31:0]  mdl_line  [16];

    l1_dcache dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] line;
        line = a & 32'hFFFF_FFE0;
        return 32'h1000_0000 + ((line ^ 32'h0000_0040) << 3) + {29'd0, a[4:2]};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        if (bstore.exists(la)) return bstore[la];
        for (int w = 0; w < 8; w++) l[w * 32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] flat_word(input logic [31:0] a);
        logic [255:0] l;
        if (flat.exists(a >> 2)) return flat[a >> 2];
        l = line_of(a & 32'hFFFF_FFE0);
        return l[int'(a[4:2]) * 32 +: 32];
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] w;
        w = flat_word(a);
        for (int k = 0; k < 4; k++) if (b[k]) w[k * 8 +: 8] = d[k * 8 +: 8];
        flat[a >> 2] = w;
    endtask

    // Physical memory: random latency, backing store updated by writebacks.
    initial begin : pmem_model
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        lat = 1;
        pmem_resp = 1'b0;
        pmem_rdata = 256'h0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) overlap_cnt++;
            if (!rst || pmem_hold || !(pmem_read || pmem_write)) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    wait_cnt = 0;
                    lat = $urandom_range(1, 4);
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        bstore[pmem_address] = pmem_wdata;
                        n_wr++;
                        last_wr_addr = pmem_address;
                        last_wr_data = pmem_wdata;
                    end else begin
                        pmem_rdata = line_of(pmem_address);
                        n_rd++;
                        last_rd_addr = pmem_address;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation exceeded 2ms");
        $fatal(1);
    end

    task automatic do_access(input bit wr, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, input bit scramble,
                             output logic [31:0] rd, output int cyc);
        bit done;
        @(negedge clk);
        mem_address = a; mem_byte_enable = b; mem_wdata = d;
        mem_read = !wr; mem_write = wr;
        cyc = 0; done = 1'b0; rd = 32'h0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                rd = mem_rdata;
                done = 1'b1;
            end else if (scramble) begin
                mem_address = $urandom; mem_byte_enable = 4'($urandom); mem_wdata = $urandom;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_timeout addr=%h: no mem_resp, required within 200 cycles", a);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        flat.delete();
        for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
        mem_address = 32'h0; mem_wdata = 32'h0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
        checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL reset_pmem_req got=%b exp=00", {pmem_read, pmem_write}); end
        checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
        checks++; if (pmem_wdata !== 256'h0) begin failures++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
        rst = 1'b1;
    endtask

    task automatic test_fill_and_hit();
        logic [31:0] rd; int cyc; int r0, w0;
        r0 = n_rd; w0 = n_wr;
        do_access(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (n_rd - r0 != 1 || last_rd_addr !== 32'h40) begin failures++; $display("FAIL fill_pmem_read count=%0d addr=%h exp count=1 addr=00000040", n_rd - r0, last_rd_addr); end
        checks++; if (n_wr != w0) begin failures++; $display("FAIL fill_no_writeback got=%0d exp=0", n_wr - w0); end
        checks++; if (rd !== 32'h1000_0000) begin failures++; $display("FAIL fill_rdata got=%h exp=10000000", rd); end
        r0 = n_rd;
        do_access(1'b0, 32'h44, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc != 1) begin failures++; $display("FAIL hit_latency got=%0d exp=1", cyc); end
        checks++; if (rd !== 32'h1000_0001) begin failures++; $display("FAIL hit_rdata got=%h exp=10000001", rd); end
        checks++; if (n_rd != r0) begin failures++; $display("FAIL hit_no_pmem got=%0d exp=0", n_rd - r0); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc; int r0;
        r0 = n_rd;
        do_access(1'b1, 32'h48, 4'b0101, 32'hDEAD_BEEF, 1'b0, rd, cyc);
        mdl_write(32'h48, 4'b0101, 32'hDEAD_BEEF);
        checks++; if (cyc != 1 || n_rd != r0) begin failures++; $display("FAIL write_hit_latency got=%0d pmem=%0d exp=1 pmem=0", cyc, n_rd - r0); end
        do_access(1'b0, 32'h48, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'h10AD_00EF) begin failures++; $display("FAIL write_merge got=%h exp=10ad00ef", rd); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; int cyc; int r0, w0;
        r0 = n_rd; w0 = n_wr;
        do_access(1'b0, 32'h240, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (n_wr - w0 != 1 || last_wr_addr !== 32'h40) begin failures++; $display("FAIL evict_write count=%0d addr=%h exp count=1 addr=00000040", n_wr - w0, last_wr_addr); end
        checks++; if (last_wr_data[95:64] !== 32'h10AD_00EF) begin failures++; $display("FAIL evict_wdata got=%h exp=10ad00ef", last_wr_data[95:64]); end
        checks++; if (n_rd - r0 != 1 || last_rd_addr !== 32'h240) begin failures++; $display("FAIL evict_fill count=%0d addr=%h exp count=1 addr=00000240", n_rd - r0, last_rd_addr); end
        checks++; if (rd !== flat_word(32'h240)) begin failures++; $display("FAIL evict_rdata got=%h exp=%h", rd, flat_word(32'h240)); end
    endtask

    task automatic test_clean_conflict();
        logic [31:0] rd; int cyc; int r0, w0;
        do_access(1'b0, 32'h48, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'h10AD_00EF) begin failures++; $display("FAIL refill_after_wb got=%h exp=10ad00ef", rd); end
        r0 = n_rd; w0 = n_wr;
        do_access(1'b0, 32'h440, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (n_wr != w0) begin failures++; $display("FAIL clean_no_writeback got=%0d exp=0", n_wr - w0); end
        checks++; if (n_rd - r0 != 1 || last_rd_addr !== 32'h440) begin failures++; $display("FAIL clean_fill count=%0d addr=%h exp count=1 addr=00000440", n_rd - r0, last_rd_addr); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int cyc; int r0; bit seen;
        pmem_hold = 1'b1;
        @(negedge clk);
        mem_address = 32'h640; mem_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        checks++; if (!seen) begin failures++; $display("FAIL midfill_pmem_read got=0 exp=1 within 20 cycles"); end
        rst = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin failures++; $display("FAIL midfill_async_drop pmem_read=%b mem_resp=%b exp 0 0", pmem_read, mem_resp); end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1; pmem_hold = 1'b0;
        flat.delete();
        r0 = n_rd;
        do_access(1'b0, 32'h640, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (n_rd - r0 != 1 || last_rd_addr !== 32'h640) begin failures++; $display("FAIL midfill_refetch count=%0d addr=%h exp count=1 addr=00000640", n_rd - r0, last_rd_addr); end
        checks++; if (rd !== flat_word(32'h640)) begin failures++; $display("FAIL midfill_rdata got=%h exp=%h", rd, flat_word(32'h640)); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; int cyc; int r0, w0;
        r0 = n_rd; w0 = n_wr;
        do_access(1'b1, 32'h3E0, 4'b1111, 32'h1234_5678, 1'b0, rd, cyc);
        mdl_write(32'h3E0, 4'b1111, 32'h1234_5678);
        checks++; if (n_rd - r0 != 1 || n_wr != w0 || last_rd_addr !== 32'h3E0) begin failures++; $display("FAIL wmiss_fill rd=%0d wr=%0d addr=%h exp rd=1 wr=0 addr=000003e0", n_rd - r0, n_wr - w0, last_rd_addr); end
        do_access(1'b0, 32'h3E0, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'h1234_5678 || cyc != 1) begin failures++; $display("FAIL wmiss_readback got=%h lat=%0d exp=12345678 lat=1", rd, cyc); end
        w0 = n_wr;
        do_access(1'b0, 32'h5E0, 4'h0, 32'h0, 1'b0, rd, cyc);
        checks++; if (n_wr - w0 != 1 || last_wr_addr !== 32'h3E0 || last_wr_data[31:0] !== 32'h1234_5678) begin failures++; $display("FAIL wmiss_dirty_wb count=%0d addr=%h word0=%h exp 1 000003e0 12345678", n_wr - w0, last_wr_addr, last_wr_data[31:0]); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] resp_seq;
        @(negedge clk);
        mem_address = 32'h5E4; mem_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            resp_seq[i] = mem_resp;
        end
        mem_read = 1'b0;
        checks++; if (resp_seq !== 6'b010101) begin failures++; $display("FAIL b2b_resp_pattern got=%b exp=010101", resp_seq); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_rd, line, victim;
        logic [255:0] exp_victim;
        logic [3:0] b;
        bit wr, hitp, exp_wb;
        int cyc, r0, w0, idx;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            idx  = $urandom_range(0, 15);
            a    = (32'($urandom_range(0, 3)) << 9) | (32'(idx) << 5) | (32'($urandom_range(0, 7)) << 2);
            wr   = 1'($urandom_range(0, 1));
            b    = 4'($urandom);
            d    = $urandom;
            line = a & 32'hFFFF_FFE0;
            hitp = mdl_valid[idx] && mdl_line[idx] == line;
            exp_wb = !hitp && mdl_valid[idx] && mdl_dirty[idx];
            victim = mdl_line[idx];
            for (int w = 0; w < 8; w++) exp_victim[w * 32 +: 32] = flat_word(victim + 32'(w * 4));
            exp_rd = flat_word(a);
            r0 = n_rd; w0 = n_wr;
            do_access(wr, a, b, d, 1'b1, rd, cyc);
            checks++; if (n_rd - r0 != (hitp ? 0 : 1) || n_wr - w0 != (exp_wb ? 1 : 0)) begin failures++; $display("FAIL rand_pmem_count addr=%h rd=%0d wr=%0d exp rd=%0d wr=%0d", a, n_rd - r0, n_wr - w0, hitp ? 0 : 1, exp_wb ? 1 : 0); end
            if (!hitp) begin
                checks++; if (last_rd_addr !== line) begin failures++; $display("FAIL rand_fill_addr got=%h exp=%h", last_rd_addr, line); end
            end else begin
                checks++; if (cyc != 1) begin failures++; $display("FAIL rand_hit_latency addr=%h got=%0d exp=1", a, cyc); end
            end
            if (exp_wb) begin
                checks++; if (last_wr_addr !== victim || last_wr_data !== exp_victim) begin failures++; $display("FAIL rand_writeback addr=%h exp=%h data mismatch=%b", last_wr_addr, victim, last_wr_data !== exp_victim); end
            end
            if (!wr) begin
                checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_rdata addr=%h got=%h exp=%h", a, rd, exp_rd); end
            end else begin
                mdl_write(a, b, d);
            end
            mdl_dirty[idx] = (hitp && mdl_dirty[idx]) || wr;
            mdl_valid[idx] = 1'b1;
            mdl_line[idx]  = line;
        end
        checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL pmem_rw_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill_and_hit();
        test_write_hit();
        test_dirty_evict();
        test_clean_conflict();
        test_reset_mid_fill();
        test_write_miss();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
